// File: rtl/issue_sched.sv
// Out-of-order issue scheduler: tag-wakeup reservation station with oldest-first select via age matrix.
// Optional macro SCHED_FAST_WAKEUP_EN lets a same-cycle wakeup broadcast make an entry eligible.
module issue_sched #(
  parameter int DEPTH = 8,
  parameter int TAGW  = 6,
  parameter int PAYW  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [TAGW-1:0]              in_src1_tag,
  input  logic                         in_src1_rdy,
  input  logic [TAGW-1:0]              in_src2_tag,
  input  logic                         in_src2_rdy,
  input  logic [TAGW-1:0]              in_dst_tag,
  input  logic [PAYW-1:0]              in_payload,
  input  logic                         wb_valid,
  input  logic [TAGW-1:0]              wb_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TAGW-1:0]              out_dst_tag,
  output logic [PAYW-1:0]              out_payload,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0]            s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
  logic [DEPTH-1:0][TAGW-1:0]  s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d, dst_q, dst_d;
  logic [DEPTH-1:0][PAYW-1:0]  pay_q, pay_d;
  // age_q[i][j] set means entry j is older than entry i
  logic [DEPTH-1:0]            age_q [DEPTH];
  logic [DEPTH-1:0]            age_d [DEPTH];
  logic [CW-1:0]               count_q, count_d;

  logic [DEPTH-1:0] elig, sel_oh, free_oh, disp_oh, iss_oh;
  logic             do_disp, do_iss;

  // Lowest invalid slot: isolate the lowest zero bit of the valid vector
  assign free_oh  = ~valid_q & (valid_q + DEPTH'(1));
  assign in_ready = ~rst & ~flush & (|free_oh);
  assign do_disp  = in_valid & in_ready;
  assign do_iss   = out_valid & out_ready & ~flush;
  assign disp_oh  = free_oh & {DEPTH{do_disp}};
  assign iss_oh   = sel_oh & {DEPTH{do_iss}};
  assign count    = count_q;

  // Per-entry eligibility
  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef SCHED_FAST_WAKEUP_EN
      elig[i] = valid_q[i]
              & (s1_rdy_q[i] | (wb_valid & (s1_tag_q[i] == wb_tag)))
              & (s2_rdy_q[i] | (wb_valid & (s2_tag_q[i] == wb_tag)));
`else
      elig[i] = valid_q[i] & s1_rdy_q[i] & s2_rdy_q[i];
`endif
    end
  end

  // Oldest eligible entry: eligible with no older eligible entry
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_oh[i] = elig[i] & ~(|(age_q[i] & elig));
    end
  end

  // Issue port mux; one-hot select makes the OR-reduction exact and zero when idle
  always_comb begin
    out_valid   = |elig;
    out_dst_tag = '0;
    out_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      out_dst_tag = out_dst_tag | ({TAGW{sel_oh[i]}} & dst_q[i]);
      out_payload = out_payload | ({PAYW{sel_oh[i]}} & pay_q[i]);
    end
  end

  // Next-state: wakeup, issue, dispatch, age update, flush
  always_comb begin
    valid_d  = valid_q;
    s1_rdy_d = s1_rdy_q;
    s2_rdy_d = s2_rdy_q;
    s1_tag_d = s1_tag_q;
    s2_tag_d = s2_tag_q;
    dst_d    = dst_q;
    pay_d    = pay_q;
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
    end
    if (flush) begin
      valid_d = '0;
    end else begin
      valid_d = (valid_q & ~iss_oh) | disp_oh;
      for (int i = 0; i < DEPTH; i++) begin
        if (disp_oh[i]) begin
          s1_tag_d[i] = in_src1_tag;
          s2_tag_d[i] = in_src2_tag;
          s1_rdy_d[i] = in_src1_rdy | (wb_valid & (in_src1_tag == wb_tag));
          s2_rdy_d[i] = in_src2_rdy | (wb_valid & (in_src2_tag == wb_tag));
          dst_d[i]    = in_dst_tag;
          pay_d[i]    = in_payload;
          age_d[i]    = valid_q;
        end else begin
          s1_rdy_d[i] = s1_rdy_q[i] | (wb_valid & valid_q[i] & (s1_tag_q[i] == wb_tag));
          s2_rdy_d[i] = s2_rdy_q[i] | (wb_valid & valid_q[i] & (s2_tag_q[i] == wb_tag));
          age_d[i]    = age_q[i] & ~disp_oh;
        end
      end
    end
    count_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_d = count_d + CW'(valid_d[i]);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      s1_rdy_q <= '0;
      s2_rdy_q <= '0;
      s1_tag_q <= '0;
      s2_tag_q <= '0;
      dst_q    <= '0;
      pay_q    <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      s1_rdy_q <= s1_rdy_d;
      s2_rdy_q <= s2_rdy_d;
      s1_tag_q <= s1_tag_d;
      s2_tag_q <= s2_tag_d;
      dst_q    <= dst_d;
      pay_q    <= pay_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= age_d[i];
      end
    end
  end
endmodule

// File: tb/tb_issue_sched.sv
// Self-checking bench for issue_sched: directed plan steps then random traffic against an
// ordered-list reference model (list position = age). Honours SCHED_FAST_WAKEUP_EN.
module tb_issue_sched;
  localparam int DEPTH = 8;
  localparam int TAGW  = 6;
  localparam int PAYW  = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready;
  logic [TAGW-1:0] in_src1_tag, in_src2_tag, in_dst_tag, wb_tag, out_dst_tag;
  logic            in_src1_rdy, in_src2_rdy, wb_valid, out_valid, out_ready;
  logic [PAYW-1:0] in_payload, out_payload;
  logic [CW-1:0]   count;

  issue_sched #(.DEPTH(DEPTH), .TAGW(TAGW), .PAYW(PAYW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_src1_tag(in_src1_tag), .in_src1_rdy(in_src1_rdy),
    .in_src2_tag(in_src2_tag), .in_src2_rdy(in_src2_rdy),
    .in_dst_tag(in_dst_tag), .in_payload(in_payload),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dst_tag(out_dst_tag), .out_payload(out_payload), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              slot;
    logic [TAGW-1:0] t1, t2, dst;
    bit              r1, r2;
    logic [PAYW-1:0] pay;
  } ent_t;

  ent_t q[$];   // oldest first
  int checks = 0;
  int passed = 0;

`ifdef SCHED_FAST_WAKEUP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  function automatic int sel_idx();
    for (int i = 0; i < q.size(); i++) begin
      bit a, b;
      a = q[i].r1 || (FAST && wb_valid && q[i].t1 == wb_tag);
      b = q[i].r2 || (FAST && wb_valid && q[i].t2 == wb_tag);
      if (a && b) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle();
    flush = 1'b0; in_valid = 1'b0; wb_valid = 1'b0; wb_tag = '0;
    in_src1_tag = '0; in_src2_tag = '0; in_src1_rdy = 1'b0; in_src2_rdy = 1'b0;
    in_dst_tag = '0; in_payload = '0;
  endtask

  task automatic disp(input logic [TAGW-1:0] t1, input bit r1, input logic [TAGW-1:0] t2,
                      input bit r2, input logic [TAGW-1:0] d);
    in_valid = 1'b1; in_src1_tag = t1; in_src1_rdy = r1; in_src2_tag = t2; in_src2_rdy = r2;
    in_dst_tag = d; in_payload = {$urandom()};
  endtask

  task automatic wb(input logic [TAGW-1:0] t);
    wb_valid = 1'b1; wb_tag = t;
  endtask

  // One clock: compare outputs against model, then advance model at the edge.
  task automatic cyc();
    int si, sz;
    bit [DEPTH-1:0] used;
    int slot;
    #1;
    si = sel_idx();
    chk("in_ready", 64'(in_ready), 64'(!rst && !flush && q.size() < DEPTH));
    chk("out_valid", 64'(out_valid), 64'(si >= 0));
    chk("out_dst_tag", 64'(out_dst_tag), (si >= 0) ? 64'(q[si].dst) : 64'd0);
    chk("out_payload", 64'(out_payload), (si >= 0) ? 64'(q[si].pay) : 64'd0);
    chk("count", 64'(count), 64'(q.size()));
    @(posedge clk);
    if (rst || flush) begin
      q.delete();
    end else begin
      sz = q.size();
      used = '0;
      foreach (q[k]) used[q[k].slot] = 1'b1;
      if (wb_valid) begin
        foreach (q[k]) begin
          if (q[k].t1 == wb_tag) q[k].r1 = 1'b1;
          if (q[k].t2 == wb_tag) q[k].r2 = 1'b1;
        end
      end
      if (si >= 0 && out_ready) q.delete(si);
      if (in_valid && sz < DEPTH) begin
        ent_t e;
        slot = 0;
        while (used[slot]) slot++;
        e.slot = slot; e.t1 = in_src1_tag; e.t2 = in_src2_tag; e.dst = in_dst_tag;
        e.pay = in_payload;
        e.r1 = in_src1_rdy || (wb_valid && in_src1_tag == wb_tag);
        e.r2 = in_src2_rdy || (wb_valid && in_src2_tag == wb_tag);
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle(); rst = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    cyc();
    rst = 1'b0;
    cyc();

    // In-order issue of three ready ops
    disp(6'd0, 1, 6'd0, 1, 6'd5); cyc();
    disp(6'd0, 1, 6'd0, 1, 6'd6); cyc();
    disp(6'd0, 1, 6'd0, 1, 6'd7); cyc();
    idle(); out_ready = 1'b1;
    repeat (4) cyc();

    // Younger ready op bypasses older waiting op; wakeup releases the older one
    disp(6'd9, 0, 6'd0, 1, 6'd1); cyc();
    disp(6'd0, 1, 6'd0, 1, 6'd2); cyc();
    idle(); cyc();
    wb(6'd9); cyc();
    idle(); repeat (2) cyc();

    // Fill all entries with nothing ready
    for (int i = 0; i < DEPTH; i++) begin
      disp(6'(20 + i), 0, 6'd0, 1, 6'(40 + i)); cyc();
    end
    disp(6'd0, 1, 6'd0, 1, 6'd60); cyc();   // rejected while full
    idle(); wb(6'd23); cyc();
    idle(); cyc();
    disp(6'd0, 1, 6'd0, 1, 6'd61); cyc();   // lands in freed slot as youngest
    idle(); cyc();
    for (int i = 0; i < DEPTH; i++) begin
      wb(6'(20 + i)); cyc();
    end
    idle(); repeat (3) cyc();

    // Same-cycle wakeup of a dispatching op
    out_ready = 1'b0;
    disp(6'd0, 1, 6'd12, 0, 6'd13); wb(6'd12); cyc();
    idle(); cyc();
    out_ready = 1'b1; cyc(); cyc();

    // Flush beats dispatch and issue
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(6'd0, 1, 6'd0, 1, 6'(30 + i)); cyc();
    end
    out_ready = 1'b1; disp(6'd0, 1, 6'd0, 1, 6'd35); flush = 1'b1; cyc();
    idle(); cyc();

    // Reset mid-operation, stale wakeups afterwards
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      disp(6'(50 + i), 0, 6'd0, 1, 6'(i + 1)); cyc();
    end
    idle(); rst = 1'b1; cyc();
    rst = 1'b0; wb(6'd50); cyc();
    wb(6'd51); out_ready = 1'b1; cyc();
    idle(); cyc();

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      if ($urandom_range(0, 99) < 60)
        disp(6'($urandom_range(0, 15)), $urandom_range(0, 9) < 3,
             6'($urandom_range(0, 15)), $urandom_range(0, 9) < 3, 6'($urandom_range(0, 63)));
      if ($urandom_range(0, 99) < 50) wb(6'($urandom_range(0, 15)));
      out_ready = ($urandom_range(0, 99) < 55);
      flush = ($urandom_range(0, 99) < 3);
      rst = ($urandom_range(0, 199) < 1);
      cyc();
    end
    rst = 1'b0; idle(); cyc();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
